// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard / SRAM-access sequencing controller for the five-stage core.
// Produces RAW hazard detection, the SRAM wait FSM and arbitrated freeze/flush/bubble strobes.
module pipe_hazard_ctrl #(
    parameter int SRAM_TIMEOUT = 16,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fwd_en,
    input  logic [3:0]       id_src1,
    input  logic             id_src1_valid,
    input  logic [3:0]       id_src2,
    input  logic             id_src2_valid,
    input  logic [3:0]       exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       mem_dest,
    input  logic             mem_wb_en,
    input  logic             mem_r_en,
    input  logic             mem_w_en,
    input  logic             sram_ready,
    input  logic             branch_taken,
    output logic             hazard,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             mem_stall,
    output logic             sram_req,
    output logic             sram_timeout,
    output logic [CNT_W-1:0] stall_count
);
    localparam int WCNT_W = $clog2(SRAM_TIMEOUT) + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic s1_exe, s2_exe, s1_mem, s2_mem, hazard_raw, mem_op;

    always_comb begin
        s1_exe = id_src1_valid && (id_src1 == exe_dest);
        s2_exe = id_src2_valid && (id_src2 == exe_dest);
        s1_mem = id_src1_valid && (id_src1 == mem_dest);
        s2_mem = id_src2_valid && (id_src2 == mem_dest);
        // With forwarding only a load in EXE cannot be bypassed in time.
        if (fwd_en)
            hazard_raw = (s1_exe || s2_exe) && exe_mem_r_en;
        else
            hazard_raw = ((s1_exe || s2_exe) && exe_wb_en) ||
                         ((s1_mem || s2_mem) && mem_wb_en);
        mem_op = mem_r_en || mem_w_en;
    end

    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        timeout_d = timeout_q;
        sram_req  = 1'b0;
        mem_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    state_d   = WAIT;
                    wcnt_d    = '0;
                    mem_stall = 1'b1;
                end
            end
            WAIT: begin
                sram_req  = 1'b1;
                mem_stall = 1'b1;
                wcnt_d    = wcnt_q + 1'b1;
                // Ready wins over timeout when both land in the same cycle.
                if (sram_ready) begin
                    state_d = DONE;
                end else if (wcnt_q == WCNT_W'(SRAM_TIMEOUT - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        sram_req  = sram_req && rst;
        mem_stall = mem_stall && rst;
        hazard    = hazard_raw && rst;
    end

    always_comb begin
        freeze_pc     = 1'b0;
        freeze_if_id  = 1'b0;
        flush_if_id   = 1'b0;
        bubble_id_exe = 1'b0;
        // A frozen EXE re-presents its branch, so memory stall outranks it.
        if (mem_stall) begin
            freeze_pc    = 1'b1;
            freeze_if_id = 1'b1;
        end else if (branch_taken && rst) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
        end else if (hazard) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
        end
        stall_d = (freeze_pc && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            wcnt_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

    assign sram_timeout = timeout_q;
    assign stall_count  = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default-parameter instance plus a small
// instance (SRAM_TIMEOUT=4, CNT_W=3) sharing inputs for timeout and saturation cases.
module tb_pipe_hazard_ctrl;
    logic       clk, rst, fwd_en;
    logic [3:0] id_src1, id_src2, exe_dest, mem_dest;
    logic       id_src1_valid, id_src2_valid, exe_wb_en, exe_mem_r_en;
    logic       mem_wb_en, mem_r_en, mem_w_en, sram_ready, branch_taken;

    logic        hz, fpc, fifid, flush, bub, mstall, req, tmo;
    logic [15:0] scnt;
    logic        s_hz, s_fpc, s_fifid, s_flush, s_bub, s_mstall, s_req, s_tmo;
    logic [2:0]  s_scnt;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl u_dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_src2_valid(id_src2_valid),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .sram_ready(sram_ready), .branch_taken(branch_taken),
        .hazard(hz), .freeze_pc(fpc), .freeze_if_id(fifid), .flush_if_id(flush),
        .bubble_id_exe(bub), .mem_stall(mstall), .sram_req(req), .sram_timeout(tmo),
        .stall_count(scnt)
    );

    pipe_hazard_ctrl #(.SRAM_TIMEOUT(4), .CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .fwd_en(fwd_en),
        .id_src1(id_src1), .id_src1_valid(id_src1_valid),
        .id_src2(id_src2), .id_src2_valid(id_src2_valid),
        .exe_dest(exe_dest), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
        .sram_ready(sram_ready), .branch_taken(branch_taken),
        .hazard(s_hz), .freeze_pc(s_fpc), .freeze_if_id(s_fifid), .flush_if_id(s_flush),
        .bubble_id_exe(s_bub), .mem_stall(s_mstall), .sram_req(s_req), .sram_timeout(s_tmo),
        .stall_count(s_scnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobes packed as {freeze_pc, freeze_if_id, flush_if_id, bubble_id_exe}
    function automatic logic [3:0] strb();
        return {fpc, fifid, flush, bub};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        fwd_en = 0; id_src1 = 0; id_src1_valid = 0; id_src2 = 0; id_src2_valid = 0;
        exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_dest = 0; mem_wb_en = 0;
        mem_r_en = 0; mem_w_en = 0; sram_ready = 0; branch_taken = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        tick();
        rst = 1;
        #1;
    endtask

    initial begin
        clear_inputs();
        rst = 0;
        tick();
        // Outputs held low during reset even with a live hazard and memory op.
        id_src1 = 3; id_src1_valid = 1; exe_dest = 3; exe_wb_en = 1; mem_r_en = 1;
        #1;
        chk("rst_hazard", hz, 0);
        chk("rst_strobes", strb(), 4'b0000);
        chk("rst_mem_stall", mstall, 0);
        tick();
        chk("rst_req", req, 0);
        chk("rst_stall_count", scnt, 0);
        chk("rst_timeout", tmo, 0);
        clear_inputs();
        rst = 1;
        #1;

        // No forwarding: EXE write match stalls and bubbles.
        id_src1 = 3; id_src1_valid = 1; exe_dest = 3; exe_wb_en = 1;
        #1;
        chk("nofwd_exe_hazard", hz, 1);
        chk("nofwd_exe_strobes", strb(), 4'b1101);
        tick();
        chk("nofwd_stall_count", scnt, 1);
        exe_wb_en = 0;
        #1;
        chk("nofwd_nowb_hazard", hz, 0);
        chk("nofwd_nowb_strobes", strb(), 4'b0000);
        mem_dest = 3; mem_wb_en = 1;
        #1;
        chk("nofwd_mem_hazard", hz, 1);
        id_src1_valid = 0;
        #1;
        chk("invalid_src_hazard", hz, 0);
        id_src2 = 3; id_src2_valid = 1;
        #1;
        chk("src2_mem_hazard", hz, 1);
        mem_wb_en = 0; id_src2_valid = 0; id_src1_valid = 1;

        // Forwarding: only load-use stalls.
        fwd_en = 1; exe_wb_en = 1; exe_mem_r_en = 0;
        #1;
        chk("fwd_alu_hazard", hz, 0);
        exe_mem_r_en = 1;
        #1;
        chk("fwd_load_hazard", hz, 1);
        chk("fwd_load_strobes", strb(), 4'b1101);
        tick();
        exe_mem_r_en = 0; exe_wb_en = 0; mem_dest = 3; mem_wb_en = 1;
        #1;
        chk("fwd_mem_hazard", hz, 0);
        chk("fwd_bubble_one_cycle", bub, 0);
        chk("fwd_stall_count", scnt, 2);
        clear_inputs();

        // SRAM read, ready on the 4th WAIT cycle.
        do_reset();
        mem_r_en = 1;
        #1;
        chk("sram_idle_stall", mstall, 1);
        chk("sram_idle_req", req, 0);
        chk("sram_idle_strobes", strb(), 4'b1100);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) sram_ready = 1;
            #1;
            chk($sformatf("sram_wait%0d_req", i), req, 1);
            chk($sformatf("sram_wait%0d_stall", i), mstall, 1);
        end
        tick();
        sram_ready = 0; mem_r_en = 0;
        #1;
        chk("sram_done_stall", mstall, 0);
        chk("sram_done_req", req, 0);
        chk("sram_done_freeze", fpc, 0);
        chk("sram_stall_count", scnt, 5);
        chk("ready_at_limit_no_timeout", s_tmo, 0);
        tick();
        chk("sram_idle_after", mstall, 0);
        chk("sram_count_held", scnt, 5);
        chk("main_no_timeout", tmo, 0);

        // Branch vs hazard vs memory stall priority.
        id_src1 = 3; id_src1_valid = 1; exe_dest = 3; exe_wb_en = 1; branch_taken = 1;
        #1;
        chk("branch_hazard_raw", hz, 1);
        chk("branch_strobes", strb(), 4'b0011);
        mem_w_en = 1;
        #1;
        chk("branch_memw_strobes", strb(), 4'b1100);
        clear_inputs();

        // Timeout on the small instance; the default instance keeps waiting.
        do_reset();
        mem_r_en = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("tmo_wait%0d_req", i), s_req, 1);
        end
        tick();
        mem_r_en = 0;
        #1;
        chk("tmo_done_req", s_req, 0);
        chk("tmo_done_stall", s_mstall, 0);
        chk("tmo_set", s_tmo, 1);
        tick();
        tick();
        chk("tmo_sticky", s_tmo, 1);
        chk("main_still_wait_req", req, 1);
        rst = 0;
        #1;
        chk("rst_mid_access_req", req, 0);
        chk("rst_mid_access_stall", mstall, 0);
        tick();
        rst = 1;
        #1;
        chk("tmo_cleared", s_tmo, 0);
        chk("small_count_cleared", s_scnt, 0);
        chk("main_idle_after_rst", req, 0);
        chk("main_count_cleared", scnt, 0);

        // Saturation of the 3-bit counter.
        id_src1 = 5; id_src1_valid = 1; exe_dest = 5; exe_wb_en = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("sat_pre", s_scnt, 6);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("sat_hold%0d", i), s_scnt, 7);
        end
        chk("main_count_nine", scnt, 9);
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
